// File: rtl/servo_load_scheduler_pkg.sv
// Shared types and default sizing for the servo load scheduler.
package servo_pkg;

  localparam int unsigned DefNumCh      = 8;
  localparam int unsigned DefFrameTicks = 2560;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

endpackage

// File: rtl/servo_load_scheduler_if.sv
// Command handshake bundle: producer drives valid/ch/duty, scheduler returns ready.
interface servo_load_scheduler_if #(
  parameter int unsigned CHW = 4
);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [CHW-1:0] cmd_ch;
  logic [7:0]     cmd_duty;

  modport master (output cmd_valid, output cmd_ch, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_duty, output cmd_ready);

endinterface

// File: rtl/servo_load_scheduler_frame_timer.sv
// Free-running servo frame counter; frame_start marks count zero.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = DefFrameTicks
) (
  input  logic clk,
  input  logic reset,
  output logic frame_start
);

  localparam int unsigned CW = $clog2(FRAME_TICKS);

  logic [CW-1:0] count_q;

  // Count 0..FRAME_TICKS-1 and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (count_q == CW'(FRAME_TICKS - 1)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign frame_start = (count_q == '0);

endmodule

// File: rtl/servo_load_scheduler.sv
// Servo load scheduler: buffers per-channel duty codes and, once per frame,
// commits pending ones in ascending channel order over a shared duty bus
// (SETUP / STROBE / HOLD, three cycles per channel).
// Optional feature: define SERVO_SCHED_BROADCAST_EN so that the all-ones
// channel index writes every channel instead of flagging an error.
module servo_load_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH      = DefNumCh,
  parameter int unsigned FRAME_TICKS = DefFrameTicks
) (
  input  logic                clk,
  input  logic                reset,
  servo_load_scheduler_if.slave cmd,
  output logic [7:0]          dutycycle,
  output logic [NUM_CH-1:0]   load,
  output logic                frame_start,
  output logic                busy,
  output logic                err_badch
);

  localparam int unsigned     CHW    = $clog2(NUM_CH + 1);
  localparam logic [CHW-1:0]  NumChW = CHW'(NUM_CH);

  state_e            state_q, state_d;
  logic [CHW-1:0]    sel_q, sel_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [7:0]        shadow_q [NUM_CH];
  logic [7:0]        duty_q, sel_duty;
  logic              err_q;
  logic              accept, ch_valid, ch_bcast;
  logic              low_found, next_found;
  logic [CHW-1:0]    low_idx, next_idx;

  servo_frame_timer #(
    .FRAME_TICKS (FRAME_TICKS)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start)
  );

  assign cmd.cmd_ready = (state_q == StIdle);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign ch_valid      = (cmd.cmd_ch < NumChW);
`ifdef SERVO_SCHED_BROADCAST_EN
  assign ch_bcast      = (cmd.cmd_ch == {CHW{1'b1}});
`else
  assign ch_bcast      = 1'b0;
`endif

  // Lowest pending channel overall, and lowest pending above the current selection.
  always_comb begin
    low_found  = 1'b0;
    low_idx    = '0;
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_found = 1'b1;
        low_idx   = CHW'(i);
        if (CHW'(i) > sel_q) begin
          next_found = 1'b1;
          next_idx   = CHW'(i);
        end
      end
    end
  end

  // Shadow value of the selected channel.
  always_comb begin
    sel_duty = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == CHW'(i)) sel_duty = shadow_q[i];
    end
  end

  // Commit sequencer next-state; frame_start is only looked at in idle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start && low_found) begin
          state_d = StSetup;
          sel_d   = low_idx;
        end
      end
      StSetup:  state_d = StStrobe;
      StStrobe: state_d = StHold;
      StHold: begin
        if (next_found) begin
          state_d = StSetup;
          sel_d   = next_idx;
        end else begin
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // Pending bits: set on accepted writes, cleared once the channel has been held.
  always_comb begin
    pending_d = pending_q;
    if (state_q == StHold) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_q == CHW'(i)) pending_d[i] = 1'b0;
      end
    end
    if (accept) begin
      if (ch_bcast) begin
        pending_d = '1;
      end else if (ch_valid) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cmd.cmd_ch == CHW'(i)) pending_d[i] = 1'b1;
        end
      end
    end
  end

  // Sequencer, pending and error state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      if (accept && !ch_valid && !ch_bcast) err_q <= 1'b1;
    end
  end

  // Shadow registers, last write wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_bcast || (cmd.cmd_ch == CHW'(i))) shadow_q[i] <= cmd.cmd_duty;
      end
    end
  end

  // Capture the driven duty at the end of SETUP so the bus holds it afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
    end else if (state_q == StSetup) begin
      duty_q <= sel_duty;
    end
  end

  // Strobe decode straight from state so reset drops it without waiting for a clock.
  always_comb begin
    load = '0;
    if (state_q == StStrobe) begin
      for (int i = 0; i < NUM_CH; i++) load[i] = (sel_q == CHW'(i));
    end
  end

  assign dutycycle = (state_q == StSetup) ? sel_duty : duty_q;
  assign busy      = (state_q != StIdle);
  assign err_badch = err_q;

endmodule

// File: tb/tb_servo_load_scheduler.sv
// Bench for servo_load_scheduler: scoreboard of expected (channel, duty) commits.
module tb_servo_load_scheduler;

  localparam int NCH = 8;
  localparam int CHW = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     dutycycle;
  logic [NCH-1:0] load;
  logic           frame_start, busy, err_badch;

  servo_load_scheduler_if #(.CHW(CHW)) cmd_if ();

  servo_load_scheduler #(
    .NUM_CH      (NCH),
    .FRAME_TICKS (2560)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd_if),
    .dutycycle   (dutycycle),
    .load        (load),
    .frame_start (frame_start),
    .busy        (busy),
    .err_badch   (err_badch)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  int             busy_cycles = 0;
  int             strobes = 0;
  logic [11:0]    exp_q[$];
  logic [11:0]    mon_e;
  logic [7:0]     mon_load;
  logic [7:0]     m_shadow [NCH];
  logic [NCH-1:0] m_pend;

`ifdef SERVO_SCHED_BROADCAST_EN
  localparam bit Bcast = 1'b1;
`else
  localparam bit Bcast = 1'b0;
`endif

  // Every strobe must be one-hot and match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy === 1'b1) busy_cycles++;
      if (load !== '0) begin
        strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: load=%b dutycycle=%h, required no strobe",
                   load, dutycycle);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_load = 8'd1 << mon_e[11:8];
          if (load !== mon_load || dutycycle !== mon_e[7:0]) begin
            errors++;
            $display("FAIL strobe_order: load=%b duty=%h, required load=%b duty=%h",
                     load, dutycycle, mon_load, mon_e[7:0]);
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] ch, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = ch;
    cmd_if.cmd_duty  = d;
    while (cmd_if.cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cmd_ready=%b, required 1", cmd_if.cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    if (ch < NCH) begin
      m_shadow[ch[2:0]] = d;
      m_pend[ch[2:0]]   = 1'b1;
    end else if (Bcast && ch == 4'hF) begin
      for (int i = 0; i < NCH; i++) m_shadow[i] = d;
      m_pend = '1;
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < NCH; i++) begin
      if (m_pend[i]) exp_q.push_back({4'(i), m_shadow[i]});
    end
    m_pend = '0;
  endtask

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: frame_start=%b, required 1", frame_start);
    end
    busy_cycles = 0;
    strobes     = 0;
  endtask

  task automatic test_reset();
    int mism = 0;
    int loadbad = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (load !== '0) begin errors++; $display("FAIL rst_load: %b, required 0", load); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", busy); end
    checks++;
    if (err_badch !== 1'b0) begin errors++; $display("FAIL rst_err: %b, required 0", err_badch); end
    checks++;
    if (dutycycle !== 8'h00) begin errors++; $display("FAIL rst_duty: %h, required 00", dutycycle); end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready: %b, required 1", cmd_if.cmd_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_cycle0: %b, required 1", frame_start); end
    for (int k = 1; k <= 5120; k++) begin
      @(negedge clk);
      if (frame_start !== ((k % 2560) == 0)) mism++;
      if (load !== '0) loadbad++;
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL fs_pattern: %0d wrong cycles, required 0", mism); end
    checks++;
    if (loadbad != 0) begin errors++; $display("FAIL idle_load: %0d strobes, required 0", loadbad); end
  endtask

  task automatic test_single();
    repeat (9) @(negedge clk);
    send(4'd3, 8'h40);
    push_expected();
    wait_frame();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dutycycle !== 8'h40 || load !== '0) begin
      errors++;
      $display("FAIL setup: busy=%b duty=%h load=%b, required 1 40 0", busy, dutycycle, load);
    end
    @(negedge clk);
    checks++;
    if (load !== 8'h08) begin errors++; $display("FAIL strobe3: %b, required 00001000", load); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || load !== '0) begin
      errors++; $display("FAIL hold: busy=%b load=%b, required 1 0", busy, load);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dutycycle !== 8'h40) begin
      errors++; $display("FAIL idle_hold: busy=%b duty=%h, required 0 40", busy, dutycycle);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy_cycles != 3) begin errors++; $display("FAIL busy3: %0d, required 3", busy_cycles); end
  endtask

  task automatic test_last_wins();
    send(4'd5, 8'h10);
    send(4'd1, 8'h20);
    send(4'd5, 8'h30);
    push_expected();
    wait_frame();
    repeat (20) @(negedge clk);
    checks++;
    if (busy_cycles != 6) begin errors++; $display("FAIL busy6: %0d, required 6", busy_cycles); end
    checks++;
    if (strobes != 2) begin errors++; $display("FAIL strobes2: %0d, required 2", strobes); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_broadcast();
    send(4'hF, 8'h80);
    push_expected();
    wait_frame();
    repeat (40) @(negedge clk);
    checks++;
    if (busy_cycles != (Bcast ? 24 : 0)) begin
      errors++; $display("FAIL bcast_busy: %0d, required %0d", busy_cycles, Bcast ? 24 : 0);
    end
    checks++;
    if (strobes != (Bcast ? 8 : 0)) begin
      errors++; $display("FAIL bcast_strobes: %0d, required %0d", strobes, Bcast ? 8 : 0);
    end
    checks++;
    if (err_badch !== !Bcast) begin
      errors++; $display("FAIL bcast_err: %b, required %b", err_badch, !Bcast);
    end
  endtask

  task automatic test_badch();
    send(4'd9, 8'h55);
    checks++;
    if (err_badch !== 1'b1) begin errors++; $display("FAIL badch_err: %b, required 1", err_badch); end
    push_expected();
    wait_frame();
    repeat (20) @(negedge clk);
    checks++;
    if (strobes != 0 || busy_cycles != 0) begin
      errors++; $display("FAIL badch_commit: strobes=%0d busy=%0d, required 0 0", strobes, busy_cycles);
    end
    checks++;
    if (err_badch !== 1'b1) begin errors++; $display("FAIL badch_sticky: %b, required 1", err_badch); end
  endtask

  task automatic test_reset_mid();
    send(4'd2, 8'h22);
    send(4'd6, 8'h66);
    exp_q.push_back({4'd2, 8'h22});
    m_pend = '0;
    wait_frame();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (load !== 8'h04) begin errors++; $display("FAIL strobe2: %b, required 00000100", load); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (load !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: load=%b busy=%b, required 0 0", load, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NCH; i++) m_shadow[i] = 8'h00;
    checks++;
    if (err_badch !== 1'b0) begin errors++; $display("FAIL rst_mid_err: %b, required 0", err_badch); end
    wait_frame();
    wait_frame();
    repeat (40) @(negedge clk);
    checks++;
    if (strobes != 0 || busy_cycles != 0) begin
      errors++; $display("FAIL rst_discard: strobes=%0d busy=%0d, required 0 0", strobes, busy_cycles);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_final: %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_duty  = '0;
    m_pend           = '0;
    for (int i = 0; i < NCH; i++) m_shadow[i] = 8'h00;
    test_reset();
    test_single();
    test_last_wins();
    test_broadcast();
    test_badch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
